// File: rtl/multibyte_add_pkg.sv
// Shared types and helpers for the byte-serial multibyte adder.
package multibyte_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte index width: max(1, clog2(nbytes)).
    function automatic int idx_width(input int nbytes);
        return (nbytes <= 2) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/eight_bit_adder.sv
// Combinational 8-bit ripple adder used as the shared byte datapath.
module eight_bit_adder (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'b0, cin_i};

endmodule

// File: rtl/multibyte_add_sequencer.sv
// Adds two NBYTES-wide operands one byte per cycle, LSB first, over a single 8-bit adder.
// Optional signed overflow flag when MULTIBYTE_ADD_OVERFLOW_EN is defined.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for operands; in_ready high
// ADD   | one byte per cycle through the adder, carry chained in carry_q
// DONE  | result presented; held until out_ready
module multibyte_add_sequencer
    import multibyte_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  busy
`ifdef MULTIBYTE_ADD_OVERFLOW_EN
    ,
    output logic                  overflow
`endif
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t             state_q, state_d;
    logic [W-1:0]       a_sh_q, a_sh_d;
    logic [W-1:0]       b_sh_q, b_sh_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [BYTE_W-1:0]  add_sum;
    logic               add_cout;
    logic [W+BYTE_W-1:0] sum_cat;

    eight_bit_adder u_adder (
        .a_i    (a_sh_q[BYTE_W-1:0]),
        .b_i    (b_sh_q[BYTE_W-1:0]),
        .cin_i  (carry_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // New byte enters at the top so byte i ends up in sum[8i+7:8i] after NBYTES shifts.
    assign sum_cat = {add_sum, sum_q};

`ifdef MULTIBYTE_ADD_OVERFLOW_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
`ifdef MULTIBYTE_ADD_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d   = sum_cat[W+BYTE_W-1:BYTE_W];
                carry_d = add_cout;
                a_sh_d  = a_sh_q >> BYTE_W;
                b_sh_d  = b_sh_q >> BYTE_W;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
`ifdef MULTIBYTE_ADD_OVERFLOW_EN
                    // On the last byte, bit 7 of the shift registers is the operand MSB.
                    ovf_d = (a_sh_q[BYTE_W-1] == b_sh_q[BYTE_W-1]) &&
                            (add_sum[BYTE_W-1] != a_sh_q[BYTE_W-1]);
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

`ifdef MULTIBYTE_ADD_OVERFLOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = (state_q == DONE) ? carry_q : 1'b0;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Self-checking bench for multibyte_add_sequencer (NBYTES=4): vector table, hand sequences, random ops.
module tb_multibyte_add_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          busy;
`ifdef MULTIBYTE_ADD_OVERFLOW_EN
    logic          overflow;
`endif

    multibyte_add_sequencer #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef MULTIBYTE_ADD_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int acc_q[$];
    logic [W:0] res_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes seen at the negedge complete on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready)   acc_q.push_back(cyc + 1);
        if (rst_n && out_valid && out_ready) res_q.push_back({cout, sum});
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_accept();
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("accept_timeout", 64'(t), 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        if (lat >= 200) chk("result_timeout", 64'(lat), 64'd0);
    endtask

    task automatic take_result();
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic [W-1:0] es, input logic eco,
                          input logic eov, input int hold);
        int lat;
        @(posedge clk);
        #1;
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        wait_accept();
        wait_result(lat);
        chk({nm, "_latency"}, 64'(lat), 64'(NB));
        chk({nm, "_sum"}, 64'(sum), 64'(es));
        chk({nm, "_cout"}, 64'(cout), 64'(eco));
`ifdef MULTIBYTE_ADD_OVERFLOW_EN
        chk({nm, "_ovf"}, 64'(overflow), 64'(eov));
`else
        if (eov === 1'bx) $display("unused");
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, "_hold_sum"}, 64'(sum), 64'(es));
            chk({nm, "_hold_valid"}, 64'(out_valid), 64'd1);
        end
        take_result();
        @(negedge clk);
        chk({nm, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({nm, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic cv);
        logic [W:0] t;
        logic       ov;
        t  = {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
        ov = (av[W-1] == bv[W-1]) && (t[W-1] != av[W-1]);
        return {ov, t};
    endfunction

    vec_t vt[6];

    initial begin
        int lat;
        int hs;
        int t;
        logic [W-1:0] ra, rb;
        logic rc;
        logic [W+1:0] m;
        logic [W-1:0] bb_a[3];
        logic [W-1:0] bb_b[3];

        vt[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vt[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vt[2] = '{32'h80000000, 32'h80000000, 1'b1, 32'h00000001, 1'b1, 1'b1};
        vt[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vt[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vt[5] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
`ifdef MULTIBYTE_ADD_OVERFLOW_EN
        chk("rst_ovf", 64'(overflow), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin,
                   vt[i].s, vt[i].co, vt[i].ov, 0);

        // Backpressure: result held, new operands refused until after the out handshake.
        @(posedge clk);
        #1;
        a = 32'hFAFAFAFA; b = 32'h01010101; cin = 1'b0; in_valid = 1'b1;
        wait_accept();
        wait_result(lat);
        chk("bp_latency", 64'(lat), 64'(NB));
        @(posedge clk);
        #1;
        a = 32'h00000003; b = 32'h00000004; cin = 1'b0; in_valid = 1'b1;
        acc_q.delete();
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            chk("bp_sum", 64'(sum), 64'hFBFBFBFB);
            chk("bp_cout", 64'(cout), 64'd0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        chk("bp_no_accept", 64'(acc_q.size()), 64'd0);
        take_result();
        hs = cyc;
        wait_accept();
        chk("bp_accept_cycle", 64'(acc_q.size() > 0 ? acc_q[0] : -1), 64'(hs + 1));
        wait_result(lat);
        chk("bp_next_sum", 64'(sum), 64'd7);
        take_result();

        // Reset during the second ADD cycle.
        @(posedge clk);
        #1;
        a = 32'h11111111; b = 32'h22222222; cin = 1'b1; in_valid = 1'b1;
        wait_accept();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_sum", 64'(sum), 64'd0);
        chk("mid_rst_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 32'd40, 32'd6, 1'b0, 32'd46, 1'b0, 1'b0, 0);

        // Back-to-back with in_valid and out_ready held high.
        bb_a[0] = 32'h01020304; bb_b[0] = 32'hF0F0F0F0;
        bb_a[1] = 32'hFFFF0000; bb_b[1] = 32'h00010000;
        bb_a[2] = 32'hDEADBEEF; bb_b[2] = 32'h21524111;
        acc_q.delete();
        res_q.delete();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = bb_a[i]; b = bb_b[i]; cin = 1'b0; in_valid = 1'b1;
            t = 0;
            while (acc_q.size() <= i && t < 100) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (t >= 100) chk("b2b_accept_timeout", 64'(t), 64'd0);
        end
        in_valid = 1'b0;
        t = 0;
        while (res_q.size() < 3 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) chk("b2b_result_timeout", 64'(t), 64'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m = model(bb_a[i], bb_b[i], 1'b0);
            chk($sformatf("b2b_res%0d", i),
                64'(res_q.size() > i ? res_q[i] : '1), 64'(m[W:0]));
        end
        for (int i = 0; i < 2; i++)
            chk($sformatf("b2b_spacing%0d", i),
                64'(acc_q.size() > i + 1 ? acc_q[i+1] - acc_q[i] : -1), 64'(NB + 2));

        // Random operations against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom();
            rb = $urandom();
            rc = 1'($urandom_range(0, 1));
            if (i % 6 == 0) ra = 32'hFFFFFFFF;
            m = model(ra, rb, rc);
            run_op($sformatf("rnd%0d", i), ra, rb, rc, m[W-1:0], m[W], m[W+1],
                   $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
